// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receiver and RAM word packer.
package ps2_pkg;

  localparam int unsigned PS2_FRAME_BITS = 11;
  localparam int unsigned PS2_DATA_BITS  = 8;
  localparam int unsigned RAM_WORD_W     = 32;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned CNT_W          = $clog2(BYTES_PER_WORD + 1);

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } ps2_state_e;

  // Odd parity holds when data plus parity bit contain an odd number of ones.
  function automatic logic odd_parity(input logic [PS2_DATA_BITS-1:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronizers, falling-edge detect, frame FSM and parity check.
// Optional stalled-frame abort when PS2_TIMEOUT_EN is defined.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ps2_clk,
  input  logic                     ps2_data,
  output logic                     byte_valid,
  output logic [PS2_DATA_BITS-1:0] byte_out,
  output logic                     frame_err
);

  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
  logic                   clk_prev_q;
  logic                   fall, data_bit, timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  assign fall     = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
  assign data_bit = data_sync_q[SYNC_STAGES-1];

  ps2_state_e               state_q, state_d;
  logic [2:0]               bit_cnt_q, bit_cnt_d;
  logic [PS2_DATA_BITS-1:0] shift_q, shift_d, byte_q, byte_d;
  logic                     parity_q, parity_d, valid_q, valid_d, err_q, err_d;

`ifdef PS2_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else if (fall || state_q == StIdle) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + TO_W'(1);
    end
  end

  assign timeout = (state_q != StIdle) && !fall && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    byte_d    = byte_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    if (fall) begin
      unique case (state_q)
        StIdle: begin
          if (!data_bit) begin
            state_d   = StData;
            bit_cnt_d = '0;
          end
        end
        StData: begin
          shift_d   = {data_bit, shift_q[PS2_DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StParity;
        end
        StParity: begin
          parity_d = data_bit;
          state_d  = StStop;
        end
        StStop: begin
          if (data_bit && odd_parity(shift_q, parity_q)) begin
            valid_d = 1'b1;
            byte_d  = shift_q;
          end else begin
            err_d = 1'b1;
          end
          state_d = StIdle;
        end
      endcase
    end else if (timeout) begin
      state_d   = StIdle;
      bit_cnt_d = '0;
      err_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      byte_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      byte_q    <= byte_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign byte_valid = valid_q;
  assign byte_out   = byte_q;
  assign frame_err  = err_q;

endmodule

// File: rtl/ps2_ram_writer.sv
// Packs accepted PS/2 bytes little-endian into 32-bit words and writes them to RAM
// at a wrapping address. Optional frame timeout via PS2_TIMEOUT_EN (in ps2_rx_frame).
module ps2_ram_writer
  import ps2_pkg::*;
#(
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ps2_clk,
  input  logic                     ps2_data,
  input  logic                     flush,
  output logic                     ram_we,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic [RAM_WORD_W-1:0]    ram_data,
  output logic                     byte_valid,
  output logic [PS2_DATA_BITS-1:0] byte_out,
  output logic                     frame_err
);

  ps2_rx_frame #(
    .SYNC_STAGES   (SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .byte_valid(byte_valid),
    .byte_out  (byte_out),
    .frame_err (frame_err)
  );

  logic [RAM_WORD_W-1:0] word_q, word_d, data_q, data_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;

  always_comb begin
    word_d  = word_q;
    count_d = count_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    if (we_q) begin
      // Write cycle: clear the packer, merging in any byte that arrives now.
      addr_d  = addr_q + ADDR_W'(1);
      word_d  = '0;
      count_d = '0;
      if (byte_valid) begin
        word_d[PS2_DATA_BITS-1:0] = byte_out;
        count_d                   = CNT_W'(1);
      end
    end else begin
      if (byte_valid) begin
        word_d[count_q[1:0]*PS2_DATA_BITS +: PS2_DATA_BITS] = byte_out;
        count_d = count_q + CNT_W'(1);
      end
      if (count_d == CNT_W'(BYTES_PER_WORD) || (flush && count_d != '0)) begin
        we_d   = 1'b1;
        data_d = word_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q  <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      word_q  <= word_d;
      count_q <= count_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign ram_we   = we_q;
  assign ram_addr = addr_q;
  assign ram_data = data_q;

endmodule
